// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared definitions for the Gray code converter family.
// Holds the default code width, the tracker FSM state encoding and the
// saturation limit of the optional error counter.
package gray_conv_pkg;
    localparam int GRAY_WIDTH_DEFAULT = 4;
    localparam logic [7:0] ERR_CNT_MAX = 8'd255;
    typedef enum logic {
        UNPRIMED = 1'b0,
        TRACK    = 1'b1
    } track_state_t;
endpackage

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational Gray-to-binary decoder.
// Ports: g (Gray input, WIDTH bits) -> b (binary output, WIDTH bits).
// Each binary bit is the XOR of all Gray bits at or above its position.
module gray_to_binary #(
    parameter int WIDTH = gray_conv_pkg::GRAY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] b
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign b[i] = ^g[WIDTH-1:i];
    end
endmodule

// File: rtl/gray_step_tracker.sv
// gray_step_tracker: registered Gray decoder with up/down/hold/illegal step
// classification and a signed position counter.
// Ports: clk, rst (sync, active-high), g_in/g_valid (Gray sample + strobe),
// clr (clears pos/err_sticky), b_out/b_valid (decoded sample + pulse),
// step_up/step_dn/err (classification pulses), err_sticky, pos (signed).
// Optional macro GRAY_TRACK_ERR_CNT_EN adds err_cnt, a saturating 8-bit
// count of err pulses.
module gray_step_tracker
    import gray_conv_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH_DEFAULT,
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] g_in,
    input  logic             g_valid,
    input  logic             clr,
    output logic [WIDTH-1:0] b_out,
    output logic             b_valid,
    output logic             step_up,
    output logic             step_dn,
    output logic             err,
    output logic             err_sticky,
    output logic [POS_W-1:0] pos
`ifdef GRAY_TRACK_ERR_CNT_EN
    ,
    output logic [7:0]       err_cnt
`endif
);
    track_state_t state, state_nxt;
    logic [WIDTH-1:0] b_new, diff;
    logic up, dn, bad;

    gray_to_binary #(.WIDTH(WIDTH)) u_dec (.g(g_in), .b(b_new));

    always_ff @(posedge clk) begin
        if (rst) state <= UNPRIMED;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == UNPRIMED && g_valid) ? TRACK : state;
    end

    // b_out doubles as the baseline: it always holds the last accepted decode.
    always_comb begin
        diff = b_new - b_out;
        up   = g_valid && state == TRACK && diff == WIDTH'(1);
        dn   = g_valid && state == TRACK && diff == '1;
        bad  = g_valid && state == TRACK && diff != '0 && !up && !dn;
    end

    // clr suppresses step counting but not the err pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            b_out      <= '0;
            b_valid    <= 1'b0;
            step_up    <= 1'b0;
            step_dn    <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            pos        <= '0;
        end else begin
            if (g_valid) b_out <= b_new;
            b_valid    <= g_valid;
            step_up    <= up && !clr;
            step_dn    <= dn && !clr;
            err        <= bad;
            err_sticky <= clr ? 1'b0 : (err_sticky | bad);
            pos        <= clr ? '0 : up ? pos + POS_W'(1) : dn ? pos - POS_W'(1) : pos;
        end
    end

`ifdef GRAY_TRACK_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || clr)                      err_cnt <= '0;
        else if (bad && err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule

// File: tb/tb_gray_step_tracker.sv
// tb_gray_step_tracker: directed and random checks of gray_step_tracker
// against an arithmetic reference model (modulo differences on integers).
// Define GRAY_TRACK_ERR_CNT_EN to also exercise err_cnt.
module tb_gray_step_tracker;
    logic       clk = 1'b0;
    logic       rst, g_valid, clr;
    logic [3:0] g_in, b_out;
    logic       b_valid, step_up, step_dn, err, err_sticky;
    logic [15:0] pos;
`ifdef GRAY_TRACK_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int m_bout = 0, m_pos = 0, m_cnt = 0;
    bit m_primed = 0, m_sticky = 0;

    gray_step_tracker #(.WIDTH(4), .POS_W(16)) dut (
        .clk(clk), .rst(rst), .g_in(g_in), .g_valid(g_valid), .clr(clr),
        .b_out(b_out), .b_valid(b_valid), .step_up(step_up), .step_dn(step_dn),
        .err(err), .err_sticky(err_sticky), .pos(pos)
`ifdef GRAY_TRACK_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int dec(int g);
        int b = 0;
        for (int s = 0; s < 4; s++) b ^= g >> s;
        return b & 15;
    endfunction

    function automatic logic [3:0] gray(int x);
        int y = x & 15;
        return 4'(y ^ (y >> 1));
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply(input logic [3:0] g, input bit v, input bit c, input bit r);
        int bn, d;
        bit up, dn, er;
        g_in = g; g_valid = v; clr = c; rst = r;
        @(posedge clk);
        #1;
        up = 0; dn = 0; er = 0;
        if (r) begin
            m_bout = 0; m_pos = 0; m_sticky = 0; m_cnt = 0; m_primed = 0;
        end else begin
            if (v) begin
                bn = dec(int'(g));
                if (m_primed) begin
                    d  = (bn - m_bout + 16) % 16;
                    up = (d == 1);
                    dn = (d == 15);
                    er = (d != 0) && !up && !dn;
                end
                m_bout = bn;
                m_primed = 1;
            end
            if (c) begin
                up = 0; dn = 0;
                m_pos = 0; m_sticky = 0; m_cnt = 0;
            end else begin
                m_pos = (m_pos + int'(up) - int'(dn)) & 16'hFFFF;
                m_sticky = m_sticky | er;
                if (er && m_cnt < 255) m_cnt++;
            end
        end
        check("b_out", 32'(b_out), 32'(m_bout));
        check("b_valid", 32'(b_valid), 32'(v && !r));
        check("step_up", 32'(step_up), 32'(up));
        check("step_dn", 32'(step_dn), 32'(dn));
        check("err", 32'(err), 32'(er));
        check("err_sticky", 32'(err_sticky), 32'(m_sticky));
        check("pos", 32'(pos), 32'(m_pos));
`ifdef GRAY_TRACK_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
    endtask

    initial begin
        g_in = '0; g_valid = 0; clr = 0; rst = 1;
        apply(4'b0000, 0, 0, 1);
        apply(4'b0000, 0, 0, 1);
        check("reset_pos", 32'(pos), 32'd0);
        check("reset_b_out", 32'(b_out), 32'd0);
        // Up sweep through all 16 codes
        for (int i = 0; i < 16; i++) apply(gray(i), 1, 0, 0);
        check("sweep_pos", 32'(pos), 32'd15);
        check("sweep_b_out", 32'(b_out), 32'd15);
        check("sweep_sticky", 32'(err_sticky), 32'd0);
        // Wrap 15->0 then back 0->15
        apply(4'b0000, 1, 0, 0);
        check("wrap_up", 32'(step_up), 32'd1);
        apply(4'b1000, 1, 0, 0);
        check("wrap_dn", 32'(step_dn), 32'd1);
        // Down sweep from 0 after a clr
        apply(4'b0000, 1, 1, 0);
        for (int i = 1; i <= 5; i++) apply(gray(-i), 1, 0, 0);
        check("down_pos", 32'(pos), 32'hFFFB);
        // Illegal jump then resync
        apply(4'b0000, 1, 1, 0);
        apply(4'b0011, 1, 0, 0);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_pos", 32'(pos), 32'd0);
        apply(4'b0010, 1, 0, 0);
        check("resync_up", 32'(step_up), 32'd1);
        check("resync_sticky", 32'(err_sticky), 32'd1);
        // Holds with idle gaps
        for (int k = 0; k < 3; k++) begin
            apply(4'b0110, 1, 0, 0);
            apply(4'b1111, 0, 0, 0);
        end
        check("hold_b_out", 32'(b_out), 32'd4);
        // clr together with a legal step
        apply(4'b0000, 1, 0, 0);
        apply(4'b0001, 1, 1, 0);
        check("clr_b_out", 32'(b_out), 32'd1);
        check("clr_no_step", 32'(step_up), 32'd0);
        // Reset mid-sweep at pos=7
        apply(4'b0000, 0, 0, 1);
        for (int i = 0; i < 8; i++) apply(gray(i), 1, 0, 0);
        check("mid_pos7", 32'(pos), 32'd7);
        apply(4'b0110, 1, 0, 1);
        check("mid_rst_b_out", 32'(b_out), 32'd0);
        apply(4'b0101, 1, 0, 0);
        check("post_rst_b_out", 32'(b_out), 32'd6);
        // Random walk with occasional jumps, gaps and clears
        for (int n = 0; n < 400; n++) begin
            int sel, nxt;
            sel = int'($urandom_range(0, 5));
            nxt = sel == 0 ? m_bout : sel == 1 ? m_bout + 1 : sel == 2 ? m_bout - 1 :
                  sel == 3 ? m_bout + 1 : int'($urandom_range(0, 15));
            apply(gray(nxt), $urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 127) == 0);
        end
`ifdef GRAY_TRACK_ERR_CNT_EN
        for (int i = 0; i < 300; i++) apply(i % 2 ? 4'b0011 : 4'b0000, 1, 0, 0);
        check("cnt_sat", 32'(err_cnt), 32'd255);
        apply(4'b0000, 0, 1, 0);
        check("cnt_clr", 32'(err_cnt), 32'd0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
